if_prefetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF-ID interstage register of the five-stage RISC-V core. It owns the fetch PC and issues requests to a variable-latency, in-order instruction memory. Fetched words go into a small prefetch queue that feeds the decode stage. It absorbs decode stalls and, on a branch redirect, flushes the queue and discards stale in-flight responses.

---
 rtl/riscv_if_pkg.sv | 9 +
 rtl/if_prefetch_unit_if.sv | 31 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/if_prefetch_unit.sv | 86 ++++++++
 tb/tb_if_prefetch_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_if_pkg.sv
// Shared fetch-stage constants and types for the five-stage RISC-V front end.
package riscv_if_pkg;
    localparam int INST_W = 32;
    // Same value the interstage registers load when flushed.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;
    localparam int PC_INC   = 4;
    localparam int PC_W_DEF = 8;
    typedef logic [PC_W_DEF-1:0] pc_t;
endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the prefetch unit.
// master = prefetch unit side, slave = memory/decode environment side.
interface if_prefetch_unit_if #(
    parameter int PC_W = 8
);
    import riscv_if_pkg::*;

    logic              imem_req_valid;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Registered FIFO with clear; a push is visible at the head one cycle later.
// Clear wins over push/pop; the producer must respect o_count (overflow is asserted).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !i_clear;
    assign w_pop      = i_pop && !i_clear && (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_count == (AW+1)'(DEPTH))));
endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch PC owner: credit-limited requests to in-order imem, registered prefetch queue to decode.
// Queue output appears one cycle after a response; redirect flushes queue and drops stale responses.
module if_prefetch_unit
    import riscv_if_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_en,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    if_prefetch_unit_if.master fe
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam int            EW      = PC_W + INST_W;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic [CW:0]     w_credit_used;
    logic [PC_W-1:0] w_redirect_pc;
    logic            w_empty;
    logic            w_req_fire;
    logic            w_rsp_live;
    logic            w_rsp_keep;
    logic            w_pop;

    assign w_redirect_pc = redirect_pc & ~PC_W'(3);
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_empty       = (w_count == '0);

    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign fe.imem_req_valid = !rst && pc_en && !redirect_valid && (w_credit_used < DEPTH_C);
    assign fe.imem_req_addr  = r_fetch_pc;

    assign w_req_fire = fe.imem_req_valid && fe.imem_req_ready;
    assign w_rsp_live = fe.imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_live && (r_drop == '0);
    assign w_pop      = !w_empty && fe.inst_ready;

    assign fe.inst_valid = !w_empty;
    assign fe.inst       = w_empty ? NOP_INST : w_head[INST_W-1:0];
    assign fe.inst_pc    = w_empty ? '0 : w_head[EW-1:INST_W];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rsp_keep),
        .i_push_dat ({r_rsp_pc, fe.imem_rsp_data}),
        .i_pop      (w_pop),
        .i_clear    (redirect_valid),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= r_outstanding - CW'(w_rsp_live);
            r_drop        <= r_outstanding - CW'(w_rsp_live);
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_W'(PC_INC);
            if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + PC_W'(PC_INC);
            if (w_rsp_live && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_live);
        end
    end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a queue-based reference model and in-order memory.
module tb_if_prefetch_unit;
    import riscv_if_pkg::*;

    localparam int DEPTH = 4;

    typedef struct { pc_t addr; bit stale; }     fl_t;
    typedef struct { pc_t addr; int due; }       pd_t;
    typedef struct { pc_t pc; logic [31:0] dat; } qe_t;

    logic clk;
    logic rst;
    logic pc_en;
    logic redirect_valid;
    pc_t  redirect_pc;

    if_prefetch_unit_if #(.PC_W(8)) fe ();

    if_prefetch_unit #(
        .DEPTH    (DEPTH),
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fe             (fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  cyc    = 0;
    int  lat    = 1;
    bit  spur   = 0;

    // Reference model: decode queue, in-flight requests tagged stale/live, next fetch address.
    qe_t mq[$];
    fl_t infl[$];
    pc_t m_fetch = 8'h00;
    bit  m_init  = 0;
    // Memory environment: accepted requests awaiting their response cycle.
    pd_t pend[$];

    bit          obs_rv, obs_iv;
    pc_t         obs_addr, obs_pc;
    logic [31:0] obs_inst;

    function automatic logic [31:0] mem_word(pc_t a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          rsp_now, e_rv, m_fire, m_pop, m_rsp, dut_fire;
        pc_t         dut_addr;
        logic [31:0] m_dat;
        fl_t         f;
        rsp_now = 0;
        fe.imem_rsp_valid = 1'b0;
        fe.imem_rsp_data  = 32'h0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            fe.imem_rsp_valid = 1'b1;
            fe.imem_rsp_data  = mem_word(pend[0].addr);
            rsp_now = 1;
        end else if (!rst && spur) begin
            fe.imem_rsp_valid = 1'b1;
            fe.imem_rsp_data  = 32'hDEAD_BEEF;
        end

        @(negedge clk);
        e_rv = !rst && pc_en && !redirect_valid && (mq.size() + infl.size() < DEPTH);
        chk("req_vld", 32'(fe.imem_req_valid), 32'(e_rv));
        if (!rst && m_init) begin
            chk("req_addr", 32'(fe.imem_req_addr), 32'(m_fetch));
            chk("inst_vld", 32'(fe.inst_valid), 32'(mq.size() > 0));
            chk("inst", fe.inst, (mq.size() > 0) ? mq[0].dat : 32'h0);
            chk("inst_pc", 32'(fe.inst_pc), (mq.size() > 0) ? 32'(mq[0].pc) : 32'h0);
        end
        obs_rv   = fe.imem_req_valid;
        obs_addr = fe.imem_req_addr;
        obs_iv   = fe.inst_valid;
        obs_inst = fe.inst;
        obs_pc   = fe.inst_pc;
        dut_fire = fe.imem_req_valid && fe.imem_req_ready;
        dut_addr = fe.imem_req_addr;
        m_fire   = e_rv && fe.imem_req_ready;
        m_pop    = (mq.size() > 0) && fe.inst_ready;
        m_rsp    = fe.imem_rsp_valid;
        m_dat    = fe.imem_rsp_data;

        @(posedge clk);
        if (rst) begin
            mq.delete();
            infl.delete();
            pend.delete();
            m_fetch = 8'h00;
            m_init  = 1;
        end else begin
            if (rsp_now) void'(pend.pop_front());
            if (dut_fire) pend.push_back('{dut_addr, cyc + lat});
            if (redirect_valid) begin
                if (m_rsp && infl.size() > 0) void'(infl.pop_front());
                foreach (infl[i]) infl[i].stale = 1;
                mq.delete();
                m_fetch = {redirect_pc[7:2], 2'b00};
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_rsp && infl.size() > 0) begin
                    f = infl.pop_front();
                    if (!f.stale) mq.push_back('{f.addr, m_dat});
                end
                if (m_fire) begin
                    infl.push_back('{m_fetch, 1'b0});
                    m_fetch = m_fetch + 8'd4;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_en = 1'b0;
        redirect_valid = 1'b0;
        spur = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_iv(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = obs_iv;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        pc_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        fe.imem_req_ready = 1'b1;
        fe.imem_rsp_valid = 1'b0;
        fe.imem_rsp_data = 32'h0;
        fe.inst_ready = 1'b1;

        // 1: free run, 1-cycle memory
        do_reset();
        do_reset();
        pc_en = 1'b1; lat = 1; fe.inst_ready = 1'b1;
        tick(); chk("t1_rv0", 32'(obs_rv), 32'd1); chk("t1_addr0", 32'(obs_addr), 32'h00);
        chk("t1_iv0", 32'(obs_iv), 32'd0);
        tick(); chk("t1_addr1", 32'(obs_addr), 32'h04);
        tick(); chk("t1_iv", 32'(obs_iv), 32'd1); chk("t1_pc0", 32'(obs_pc), 32'h00);
        chk("t1_inst0", obs_inst, 32'hC0DE_0000);
        tick(); chk("t1_pc1", 32'(obs_pc), 32'h04); chk("t1_inst1", obs_inst, 32'hC0DE_0004);
        repeat (4) tick();

        // 2: decode stall fills the credit window
        do_reset();
        pc_en = 1'b1; fe.inst_ready = 1'b0;
        repeat (6) tick();
        chk("t2_full_rv", 32'(obs_rv), 32'd0); chk("t2_full_pc", 32'(obs_pc), 32'h00);
        fe.inst_ready = 1'b1; tick();
        fe.inst_ready = 1'b0; tick();
        chk("t2_one_rv", 32'(obs_rv), 32'd1); chk("t2_one_addr", 32'(obs_addr), 32'h10);
        tick();
        chk("t2_then_rv", 32'(obs_rv), 32'd0); chk("t2_then_pc", 32'(obs_pc), 32'h04);

        // 3: redirect with two 3-cycle fetches in flight
        do_reset();
        pc_en = 1'b1; fe.inst_ready = 1'b1; lat = 3;
        tick(); tick();
        chk("t3_pre_addr", 32'(obs_addr), 32'h04);
        redirect_valid = 1'b1; redirect_pc = 8'h40; tick();
        chk("t3_redir_rv", 32'(obs_rv), 32'd0);
        redirect_valid = 1'b0; tick();
        chk("t3_addr", 32'(obs_addr), 32'h40); chk("t3_iv_after", 32'(obs_iv), 32'd0);
        wait_iv("t3_seen");
        chk("t3_pc", 32'(obs_pc), 32'h40); chk("t3_inst", obs_inst, 32'hC0DE_0040);

        // 4: misaligned redirect target
        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 8'h43; tick();
        redirect_valid = 1'b0; tick();
        chk("t4_addr", 32'(obs_addr), 32'h40);
        wait_iv("t4_seen");
        chk("t4_pc", 32'(obs_pc), 32'h40);

        // 5: PC wrap, then redirect colliding with a pop and a response
        redirect_valid = 1'b1; redirect_pc = 8'hFC; tick();
        redirect_valid = 1'b0; tick();
        chk("t5_addr_fc", 32'(obs_addr), 32'hFC);
        tick(); chk("t5_addr_00", 32'(obs_addr), 32'h00);
        wait_iv("t5_seen_fc"); chk("t5_pc_fc", 32'(obs_pc), 32'hFC);
        wait_iv("t5_seen_00"); chk("t5_pc_00", 32'(obs_pc), 32'h00);
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 8'h80; tick();
        redirect_valid = 1'b0; tick();
        chk("t5_flush_iv", 32'(obs_iv), 32'd0); chk("t5_flush_addr", 32'(obs_addr), 32'h80);
        tick(); chk("t5_nopush_iv", 32'(obs_iv), 32'd0);
        tick(); chk("t5_new_iv", 32'(obs_iv), 32'd1); chk("t5_new_pc", 32'(obs_pc), 32'h80);

        // 6: reset mid-operation, then a spurious response
        do_reset();
        pc_en = 1'b1; fe.inst_ready = 1'b0; lat = 1;
        repeat (4) tick();
        chk("t6_pre_iv", 32'(obs_iv), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0; pc_en = 1'b0; tick();
        chk("t6_iv", 32'(obs_iv), 32'd0); chk("t6_inst", obs_inst, 32'h0);
        chk("t6_pc", 32'(obs_pc), 32'h00); chk("t6_addr", 32'(obs_addr), 32'h00);
        spur = 1; tick();
        spur = 0; tick();
        chk("t6_spur_iv", 32'(obs_iv), 32'd0); chk("t6_spur_rv", 32'(obs_rv), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
